// File: rtl/pipeline_hazard_unit_if.sv
// rtl/pipeline_hazard_unit_if.sv - decode/execute side signal bundle of the hazard unit
//
// Purpose: groups every non-clock/reset signal of pipeline_hazard_unit.
// Modports:
//   master - the pipeline side: drives the ID bundle, branch resolution and
//            the EX-aligned data sources; receives stall/flush/forwarding.
//   slave  - the hazard unit itself.
// Signals:
//   h_i_id_*          ID instruction bundle (valid, rs, rt, uses, dst, regwr, memrd)
//   h_i_branch_taken  taken branch resolved in EX this cycle
//   h_i_data_rs/rt    register file operands, EX-aligned
//   h_i_mem_alu       ALU result held in MEM
//   h_i_wb_data       write-back value held in WB
//   h_o_stall/flush   IF/ID hold and IF/ID kill
//   h_o_fwd_a/b       operand source select (00 regfile, 01 MEM, 10 WB)
//   h_o_op_a/b        forwarded operands
//   h_o_stall_cnt     saturating stall cycle counter
interface pipeline_hazard_unit_if #(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int CNT_WIDTH = 16
);
  logic                 h_i_id_valid;
  logic [AWIDTH-1:0]    h_i_id_rs;
  logic [AWIDTH-1:0]    h_i_id_rt;
  logic                 h_i_id_uses_rs;
  logic                 h_i_id_uses_rt;
  logic [AWIDTH-1:0]    h_i_id_dst;
  logic                 h_i_id_regwr;
  logic                 h_i_id_memrd;
  logic                 h_i_branch_taken;
  logic [DWIDTH-1:0]    h_i_data_rs;
  logic [DWIDTH-1:0]    h_i_data_rt;
  logic [DWIDTH-1:0]    h_i_mem_alu;
  logic [DWIDTH-1:0]    h_i_wb_data;
  logic                 h_o_stall;
  logic                 h_o_flush;
  logic [1:0]           h_o_fwd_a;
  logic [1:0]           h_o_fwd_b;
  logic [DWIDTH-1:0]    h_o_op_a;
  logic [DWIDTH-1:0]    h_o_op_b;
  logic [CNT_WIDTH-1:0] h_o_stall_cnt;

  modport master (
    output h_i_id_valid, h_i_id_rs, h_i_id_rt, h_i_id_uses_rs, h_i_id_uses_rt,
           h_i_id_dst, h_i_id_regwr, h_i_id_memrd, h_i_branch_taken,
           h_i_data_rs, h_i_data_rt, h_i_mem_alu, h_i_wb_data,
    input  h_o_stall, h_o_flush, h_o_fwd_a, h_o_fwd_b, h_o_op_a, h_o_op_b,
           h_o_stall_cnt
  );

  modport slave (
    input  h_i_id_valid, h_i_id_rs, h_i_id_rt, h_i_id_uses_rs, h_i_id_uses_rt,
           h_i_id_dst, h_i_id_regwr, h_i_id_memrd, h_i_branch_taken,
           h_i_data_rs, h_i_data_rt, h_i_mem_alu, h_i_wb_data,
    output h_o_stall, h_o_flush, h_o_fwd_a, h_o_fwd_b, h_o_op_a, h_o_op_b,
           h_o_stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - hazard detection and operand forwarding for the 5-stage pipeline
//
// Purpose: shadows the EX/MEM/WB instruction bundles, raises the IF/ID stall
// and branch flush, and selects the forwarded operands for the EX stage.
// Ports:
//   h_clk  - clock, rising edge
//   h_rst  - asynchronous active-high reset, drops every tracked instruction
//   bus    - pipeline_hazard_unit_if.slave (ID bundle, data sources,
//            stall/flush, forwarding selects, operands, stall counter)
// Parameters:
//   FWD_EN       1 = forward from MEM/WB, stall only on load-use
//                0 = no forwarding, stall on every RAW hazard
//   RF_WB_BYPASS 1 = register file writes before reads, WB is never a hazard
module pipeline_hazard_unit #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 5,
  parameter int FWD_EN       = 1,
  parameter int RF_WB_BYPASS = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   h_clk,
  input  logic                   h_rst,
  pipeline_hazard_unit_if.slave  bus
);

  typedef struct packed {
    logic              valid;
    logic [AWIDTH-1:0] rs;
    logic [AWIDTH-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
    logic [AWIDTH-1:0] dst;
    logic              regwr;
    logic              memrd;
  } bundle_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  bundle_t              id_b;
  bundle_t              ex_q;
  bundle_t              mem_q;
  bundle_t              wb_q;
  logic                 hazard;
  logic                 stall;
  logic                 flush;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic [CNT_WIDTH-1:0] cnt_q;

  // A stage produces register r only if it will really write it; r0 is hardwired.
  function automatic logic writes(input bundle_t b, input logic [AWIDTH-1:0] r);
    return b.valid && b.regwr && (b.dst == r) && (r != '0);
  endfunction

  function automatic logic depends(input bundle_t c, input bundle_t p);
    return (c.uses_rs && writes(p, c.rs)) || (c.uses_rt && writes(p, c.rt));
  endfunction

  // MEM is checked first so the youngest producer wins. A load in MEM is
  // skipped: its data is not ready yet, and the load-use stall keeps a
  // dependent instruction out of EX while the load sits there.
  function automatic logic [1:0] fwd_sel(input logic ex_valid, input logic uses,
                                         input logic [AWIDTH-1:0] r,
                                         input bundle_t mem, input bundle_t wb);
    if (FWD_EN == 0 || !ex_valid || !uses) return 2'b00;
    if (writes(mem, r) && !mem.memrd)      return 2'b01;
    if (writes(wb, r))                     return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [DWIDTH-1:0] op_mux(input logic [1:0] sel,
                                               input logic [DWIDTH-1:0] rf,
                                               input logic [DWIDTH-1:0] mem,
                                               input logic [DWIDTH-1:0] wb);
    case (sel)
      2'b01:   return mem;
      2'b10:   return wb;
      default: return rf;
    endcase
  endfunction

  always_comb begin
    id_b         = '0;
    id_b.valid   = bus.h_i_id_valid;
    id_b.rs      = bus.h_i_id_rs;
    id_b.rt      = bus.h_i_id_rt;
    id_b.uses_rs = bus.h_i_id_uses_rs;
    id_b.uses_rt = bus.h_i_id_uses_rt;
    id_b.dst     = bus.h_i_id_dst;
    id_b.regwr   = bus.h_i_id_regwr;
    id_b.memrd   = bus.h_i_id_memrd;
  end

  always_comb begin
    hazard = 1'b0;
    if (id_b.valid) begin
      if (FWD_EN != 0) begin
        hazard = ex_q.memrd && depends(id_b, ex_q);
      end else begin
        hazard = depends(id_b, ex_q) || depends(id_b, mem_q) ||
                 ((RF_WB_BYPASS == 0) && depends(id_b, wb_q));
      end
    end
  end

  // A taken branch kills the ID instruction, so any hazard it had is moot.
  assign flush = bus.h_i_branch_taken;
  assign stall = hazard && !flush;

  always_comb begin
    fwd_a = fwd_sel(ex_q.valid, ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
    fwd_b = fwd_sel(ex_q.valid, ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
  end

  always_ff @(posedge h_clk or posedge h_rst) begin
    if (h_rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= ex_q;
      wb_q  <= mem_q;
      ex_q  <= (stall || flush) ? '0 : id_b;
      if (stall && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

  // Source-side fields travel down MEM/WB with the bundle but only the
  // producer fields are consulted there.
  logic unused_fields;
  assign unused_fields = ^{mem_q.rs, mem_q.rt, mem_q.uses_rs, mem_q.uses_rt,
                           wb_q.rs, wb_q.rt, wb_q.uses_rs, wb_q.uses_rt, wb_q.memrd};

  assign bus.h_o_stall     = stall;
  assign bus.h_o_flush     = flush;
  assign bus.h_o_fwd_a     = fwd_a;
  assign bus.h_o_fwd_b     = fwd_b;
  assign bus.h_o_op_a      = op_mux(fwd_a, bus.h_i_data_rs, bus.h_i_mem_alu, bus.h_i_wb_data);
  assign bus.h_o_op_b      = op_mux(fwd_b, bus.h_i_data_rt, bus.h_i_mem_alu, bus.h_i_wb_data);
  assign bus.h_o_stall_cnt = cnt_q;

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Second-generation hazard and forwarding controller for the 5-stage MIPS pipeline.
- Sits between decode and execute. It tracks the destination-register bundles of in-flight instructions in EX, MEM and WB.
- It generates the IF/ID stall, the EX bubble and branch flush, and drives the forwarded operands into execute.
- Forwarding vs. stall-only operation, register-file write-through and widths are parameter-selected.

Parameters:
- DWIDTH, 32: operand/data width.
- AWIDTH, 5: register address width.
- FWD_EN, 1: 1 = forwarding from MEM/WB plus load-use stall; 0 = no forwarding, stall on any RAW hazard.
- RF_WB_BYPASS, 1: 1 = register file writes before it reads in the same cycle, so a WB producer is never a hazard; 0 = the WB producer also causes a hazard.
- CNT_WIDTH, 16: width of the stall performance counter.

Ports:
- h_clk, in, 1: clock, rising edge.
- h_rst, in, 1: asynchronous, active-high reset.
- h_i_id_valid, in, 1: the ID stage holds a real instruction.
- h_i_id_rs, in, AWIDTH: source register rs of the ID instruction.
- h_i_id_rt, in, AWIDTH: source register rt of the ID instruction.
- h_i_id_uses_rs, in, 1: the ID instruction reads rs.
- h_i_id_uses_rt, in, 1: the ID instruction reads rt.
- h_i_id_dst, in, AWIDTH: destination register (after RegDst selection).
- h_i_id_regwr, in, 1: RegWrite of the ID instruction.
- h_i_id_memrd, in, 1: MemRead of the ID instruction (load).
- h_i_branch_taken, in, 1: the EX stage resolved a taken branch this cycle.
- h_i_data_rs, in, DWIDTH: register file rs value, EX-aligned.
- h_i_data_rt, in, DWIDTH: register file rt value, EX-aligned.
- h_i_mem_alu, in, DWIDTH: ALU result currently in MEM.
- h_i_wb_data, in, DWIDTH: write-back data currently in WB.
- h_o_stall, out, 1: hold PC and the IF/ID register.
- h_o_flush, out, 1: kill the IF/ID instruction.
- h_o_fwd_a, out, 2: operand A source; 00 regfile, 01 MEM, 10 WB.
- h_o_fwd_b, out, 2: operand B source; same encoding.
- h_o_op_a, out, DWIDTH: forwarded operand A.
- h_o_op_b, out, DWIDTH: forwarded operand B.
- h_o_stall_cnt, out, CNT_WIDTH: saturating count of stall cycles.

Behaviour:
- Reset: all stage bundles go invalid and h_o_stall_cnt=0.
  - With all stages invalid: h_o_stall=0, h_o_flush=0, fwd_a/b=00, op_a/b equal data_rs/rt.
  - Reset mid-stall or mid-flush drops all tracked instructions immediately.
- Bundle contents: each of EX, MEM and WB holds {valid, rs, rt, uses_rs, uses_rt, dst, regwr, memrd}.
- Every rising edge:
  - MEM <= EX and WB <= MEM, unconditionally.
  - EX <= bubble (valid=0) if h_o_flush or h_o_stall; otherwise EX <= ID inputs, with valid = h_i_id_valid.
- Producer definition: a stage "writes r" if valid & regwr & dst==r & r!=0. Register 0 never matches.
- Hazard condition, FWD_EN=1:
  - The ID instruction is valid, EX is a load (memrd), and EX writes an rs/rt that ID uses.
  - Result: exactly 1 stall cycle per load-use pair.
- Hazard condition, FWD_EN=0:
  - The ID instruction is valid and uses a register written by EX or MEM.
  - WB is included as a producer only when RF_WB_BYPASS=0.
  - Stall persists until the producer leaves the checked stages.
- h_o_flush = h_i_branch_taken, combinational.
- h_o_stall = hazard & ~h_i_branch_taken. Flush has priority, so there is no simultaneous stall and flush.
- Forwarding is combinational and evaluated for the instruction in EX. Operand A uses EX.rs/uses_rs; operand B uses EX.rt/uses_rt.
  - FWD_EN=0: fwd_a/b are always 00.
  - 01 if MEM writes the register and MEM is not a load.
  - Otherwise 10 if WB writes the register.
  - Otherwise 00.
  - MEM has priority over WB (youngest producer wins).
  - A MEM load match cannot occur; the stall guarantees this.
- op_a/op_b are muxed from data_rs/rt, mem_alu and wb_data per fwd_a/fwd_b.
- Counter: h_o_stall_cnt increments on every edge where h_o_stall=1 and saturates at all-ones.

Test Plan:
- Reset asserted mid-sequence with a load in EX -> next cycle stall=0, fwd=00, cnt=0, and no stall is produced for the following dependent instruction.
- FWD_EN=1: add r3 followed by sub using r3 as rs -> in the sub's EX cycle fwd_a=01, op_a=h_i_mem_alu (e.g. 0x0000_0042); stall never asserted.
- FWD_EN=1: lw r5 followed by add r6=r5+r5 -> stall=1 for exactly one cycle and the EX bubble is valid=0.
  - Next cycle: fwd_a=fwd_b=10, op_a=op_b=h_i_wb_data (0xDEAD_BEEF); cnt=1.
- r2 written in both MEM and WB (different values 0x11/0x22), EX reads r2 -> fwd=01, op=0x11. Writes to r0 -> fwd=00 always.
- FWD_EN=0, RF_WB_BYPASS=1: addi r4 followed by a dependent instruction -> stall held 2 cycles, then released; cnt=2.
- Branch taken while a load-use hazard is present -> flush=1, stall=0, EX receives a bubble, cnt unchanged.
